// File: rtl/spcore_seq.sv
// spcore_seq: fetch/decode sequencer driving the spcore control bundle and data-memory strobes.
module spcore_seq #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [3:0]      x,
  output logic [3:0]      y,
  output logic [3:0]      z,
  output logic [15:0]     I,
  output logic [3:0]      aluc,
  output logic [1:0]      s2,
  output logic            reg_we,
  output logic            en,
  output logic            mem_we,
  output logic            mem_re,
  input  logic            mem_ready
);
  localparam logic [3:0] ALUC_CLEAR   = 4'd0;
  localparam logic [3:0] ALUC_ADD     = 4'd1;
  localparam logic [3:0] ALUC_MUL     = 4'd2;
  localparam logic [3:0] ALUC_MAD     = 4'd3;
  localparam logic [3:0] ALUC_CORE_ID = 4'd4;
  localparam logic [3:0] ALUC_N_CORES = 4'd5;
  localparam logic [1:0] MUXD_FROM_I   = 2'd0;
  localparam logic [1:0] MUXD_FROM_ALU = 2'd1;
  localparam logic [1:0] MUXD_FROM_MEM = 2'd2;
  localparam logic [3:0] OP_LOADI = 4'h1, OP_ADD = 4'h2, OP_MUL = 4'h3, OP_MAD = 4'h4;
  localparam logic [3:0] OP_LDCID = 4'h5, OP_LDCN = 4'h6, OP_LOAD = 4'h7, OP_STORE = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9, OP_HALT = 4'hF;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE} state_t;
  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic            r_err;
  logic [31:0]     w_ir;
  logic [3:0]      w_op;
  logic [3:0]      w_alu;
  logic            w_legal;
  logic            w_exwb;
  // The fresh word is visible during DECODE; afterwards the latched copy holds the fields.
  assign w_ir    = (r_state == S_DECODE) ? imem_data : r_ir;
  assign w_op    = w_ir[31:28];
  assign w_legal = (w_op <= OP_JMP) || (w_op == OP_HALT);
  assign w_exwb  = (r_state == S_EXEC) || (r_state == S_WB);
  assign w_alu   = (w_op == OP_ADD)   ? ALUC_ADD :
                   (w_op == OP_MUL)   ? ALUC_MUL :
                   (w_op == OP_MAD)   ? ALUC_MAD :
                   (w_op == OP_LDCID) ? ALUC_CORE_ID :
                   (w_op == OP_LDCN)  ? ALUC_N_CORES : ALUC_CLEAR;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= START_PC;
      r_ir    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_pc  <= START_PC;
        r_err <= 1'b0;
      end
      if (r_state == S_DECODE) begin
        r_ir <= imem_data;
        r_pc <= (w_op == OP_JMP) ? imem_data[PC_W-1:0] : r_pc + 1'b1;
        if (!w_legal) r_err <= 1'b1;
      end
    end
  end
  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    en        = busy;
    done      = (r_state == S_DONE);
    err       = r_err;
    imem_addr = r_pc;
    x         = w_ir[27:24];
    y         = w_ir[23:20];
    z         = w_ir[19:16];
    I         = w_ir[15:0];
    aluc      = w_exwb ? w_alu : ALUC_CLEAR;
    s2        = !w_exwb                ? MUXD_FROM_I :
                (w_alu != ALUC_CLEAR)  ? MUXD_FROM_ALU :
                (w_op == OP_LOAD)      ? MUXD_FROM_MEM : MUXD_FROM_I;
    reg_we    = (r_state == S_WB);
    mem_we    = (r_state == S_MEM) && (w_op == OP_STORE);
    mem_re    = (r_state == S_MEM) && (w_op == OP_LOAD);
    unique case (r_state)
      S_IDLE:   w_next = start ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (w_op == OP_HALT)                       ? S_DONE :
                         (w_op == OP_LOADI)                      ? S_WB :
                         (w_alu != ALUC_CLEAR)                   ? S_EXEC :
                         (w_op == OP_LOAD || w_op == OP_STORE)   ? S_MEM : S_FETCH;
      S_EXEC:   w_next = S_WB;
      S_MEM:    w_next = !mem_ready ? S_MEM : (w_op == OP_STORE) ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_spcore_seq.sv
// tb_spcore_seq: directed cycle-exact checks of the spcore_seq sequencer against a synchronous imem model.
module tb_spcore_seq;
  logic        clk = 1'b0;
  logic        reset, start, mem_ready;
  logic        busy, done, err, reg_we, en, mem_we, mem_re;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [3:0]  x, y, z, aluc;
  logic [15:0] ii;
  logic [1:0]  s2;
  logic [31:0] mem [256];
  int n_cmp = 0, n_err = 0, n_we = 0, n_mw = 0, snap = 0;

  spcore_seq dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .imem_addr(imem_addr), .imem_data(imem_data), .x(x), .y(y), .z(z), .I(ii),
    .aluc(aluc), .s2(s2), .reg_we(reg_we), .en(en), .mem_we(mem_we), .mem_re(mem_re),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= mem[imem_addr];
  always @(negedge clk) begin
    if (reg_we) n_we <= n_we + 1;
    if (mem_we) n_mw <= n_mw + 1;
  end

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic [15:0] imm);
    return {op, a, b, c, imm};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_prog_a();
    mem[0] = ins(4'h1, 4'd0, 4'd0, 4'd0, 16'd11);
    mem[1] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd20);
    mem[2] = ins(4'h2, 4'd2, 4'd0, 4'd1, 16'd0);
    mem[3] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
  endtask

  task automatic go();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0;
    step(2);
    chk("rst busy", busy, 0);   chk("rst done", done, 0);   chk("rst err", err, 0);
    chk("rst addr", imem_addr, 0); chk("rst aluc", aluc, 0); chk("rst s2", s2, 0);
    chk("rst reg_we", reg_we, 0); chk("rst en", en, 0);
    chk("rst mem_we", mem_we, 0); chk("rst mem_re", mem_re, 0);
    chk("rst xyzI", {x, y, z, ii}, 0);
    reset = 1'b1;
    step(1);
    chk("idle en", en, 0);
    // Test 1: LOADI, LOADI, ADD, HALT
    load_prog_a();
    snap = n_we;
    go();
    chk("t1 c0 busy", busy, 1); chk("t1 c0 en", en, 1); chk("t1 c0 addr", imem_addr, 0);
    step(1);
    chk("t1 c1 x", x, 0); chk("t1 c1 I", ii, 11); chk("t1 c1 reg_we", reg_we, 0);
    step(1);
    chk("t1 c2 reg_we", reg_we, 1); chk("t1 c2 x", x, 0); chk("t1 c2 I", ii, 11);
    chk("t1 c2 s2", s2, 0); chk("t1 c2 aluc", aluc, 0);
    step(1);
    chk("t1 c3 reg_we", reg_we, 0); chk("t1 c3 addr", imem_addr, 1);
    step(2);
    chk("t1 c5 reg_we", reg_we, 1); chk("t1 c5 x", x, 1); chk("t1 c5 I", ii, 20);
    step(2);
    chk("t1 c7 xyz", {x, y, z}, 12'h201); chk("t1 c7 reg_we", reg_we, 0);
    step(1);
    chk("t1 c8 aluc", aluc, 1); chk("t1 c8 s2", s2, 1); chk("t1 c8 reg_we", reg_we, 0);
    step(1);
    chk("t1 c9 reg_we", reg_we, 1); chk("t1 c9 aluc", aluc, 1); chk("t1 c9 x", x, 2);
    step(2);
    chk("t1 c11 done", done, 0); chk("t1 c11 busy", busy, 1);
    step(1);
    chk("t1 c12 done", done, 1); chk("t1 c12 busy", busy, 0); chk("t1 c12 en", en, 0);
    step(1);
    chk("t1 c13 done", done, 0); chk("t1 c13 en", en, 0);
    chk("t1 we pulses", n_we - snap, 3);
    // Test 2: MAD, MUL, LDCID, LDCN, HALT
    mem[0] = ins(4'h4, 4'd2, 4'd0, 4'd1, 16'd0);
    mem[1] = ins(4'h3, 4'd2, 4'd0, 4'd1, 16'd0);
    mem[2] = ins(4'h5, 4'd3, 4'd0, 4'd0, 16'd0);
    mem[3] = ins(4'h6, 4'd4, 4'd0, 4'd0, 16'd0);
    mem[4] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    go();
    step(2);
    chk("t2 c2 aluc", aluc, 3); chk("t2 c2 s2", s2, 1); chk("t2 c2 reg_we", reg_we, 0);
    step(1);
    chk("t2 c3 reg_we", reg_we, 1); chk("t2 c3 aluc", aluc, 3);
    step(1);
    chk("t2 c4 addr", imem_addr, 1); chk("t2 c4 reg_we", reg_we, 0);
    step(2);
    chk("t2 c6 aluc", aluc, 2); chk("t2 c6 s2", s2, 1); chk("t2 c6 reg_we", reg_we, 0);
    step(1);
    chk("t2 c7 reg_we", reg_we, 1);
    step(1);
    chk("t2 c8 addr", imem_addr, 2);
    step(2);
    chk("t2 c10 aluc", aluc, 4);
    step(4);
    chk("t2 c14 aluc", aluc, 5);
    step(4);
    chk("t2 c18 done", done, 1);
    step(1);
    // Test 3: STORE with three wait cycles, then LOAD with ready already high
    mem[0] = ins(4'h8, 4'd5, 4'd1, 4'd2, 16'h0040);
    mem[1] = ins(4'h7, 4'd6, 4'd1, 4'd2, 16'h0044);
    mem[2] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    snap = n_mw;
    go();
    step(2);
    chk("t3 c2 mem_we", mem_we, 1); chk("t3 c2 reg_we", reg_we, 0); chk("t3 c2 mem_re", mem_re, 0);
    step(1);
    chk("t3 c3 mem_we", mem_we, 1);
    step(1);
    chk("t3 c4 mem_we", mem_we, 1);
    step(1);
    chk("t3 c5 mem_we", mem_we, 1); chk("t3 c5 reg_we", reg_we, 0);
    mem_ready = 1'b1;
    step(1);
    chk("t3 c6 mem_we", mem_we, 0); chk("t3 c6 addr", imem_addr, 1);
    chk("t3 mem_we cycles", n_mw - snap, 4);
    step(1);
    chk("t3 c7 mem_re", mem_re, 0);
    step(1);
    chk("t3 c8 mem_re", mem_re, 1); chk("t3 c8 mem_we", mem_we, 0);
    step(1);
    chk("t3 c9 reg_we", reg_we, 1); chk("t3 c9 s2", s2, 2); chk("t3 c9 aluc", aluc, 0);
    chk("t3 c9 mem_re", mem_re, 0); chk("t3 c9 x", x, 6);
    mem_ready = 1'b0;
    step(1);
    chk("t3 c10 addr", imem_addr, 2);
    step(2);
    chk("t3 c12 done", done, 1);
    step(1);
    // Test 4: JMP 0xFF, illegal op at 0xFF, PC wraps to 0
    mem[0]   = ins(4'h9, 4'd0, 4'd0, 4'd0, 16'h00FF);
    mem[255] = ins(4'hC, 4'd0, 4'd0, 4'd0, 16'd0);
    go();
    chk("t4 c0 err", err, 0);
    step(2);
    chk("t4 c2 addr", imem_addr, 8'hFF);
    mem[0] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    step(1);
    chk("t4 c3 err", err, 0);
    step(1);
    chk("t4 c4 addr", imem_addr, 0); chk("t4 c4 err", err, 1);
    step(2);
    chk("t4 c6 done", done, 1); chk("t4 c6 err", err, 1);
    step(3);
    chk("t4 idle err", err, 1);
    // Test 5: reset during ADD write-back, then rerun; test 6: start while busy
    load_prog_a();
    go();
    chk("t5 c0 err cleared", err, 0);
    step(9);
    chk("t5 c9 reg_we", reg_we, 1);
    reset = 1'b0;
    step(1);
    chk("t5 rst reg_we", reg_we, 0); chk("t5 rst busy", busy, 0); chk("t5 rst en", en, 0);
    chk("t5 rst addr", imem_addr, 0); chk("t5 rst done", done, 0);
    reset = 1'b1;
    step(1);
    go();
    chk("t5 c0 addr", imem_addr, 0);
    step(3);
    chk("t6 c3 addr", imem_addr, 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t6 c4 addr", imem_addr, 1); chk("t6 c4 I", ii, 20); chk("t6 c4 x", x, 1);
    chk("t6 c4 busy", busy, 1);
    step(5);
    chk("t6 c9 reg_we", reg_we, 1); chk("t6 c9 x", x, 2); chk("t6 c9 aluc", aluc, 1);
    step(3);
    chk("t6 c12 done", done, 1);
    step(1);
    chk("t6 c13 busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
